arm_fetch_unit: RTL and testbench
=================================

Name: arm_fetch_unit

Overview:
Parametrised instruction-fetch front end for the ARM core. It replaces the direct inst_addr/inst wiring with a request/acknowledge memory interface and a prefetch FIFO of configurable depth. It also provides branch redirect with flush, and halt/drain control. It sits between instruction memory and the decode stage and feeds decode one word per valid/ready handshake.

Parameters:
ADDR_W, 30, word-address width; byte address = {addr, 2'b00}
DEPTH, 4, prefetch FIFO entries; power of two, 2..16
RESET_PC, 0, word address fetched first after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  word address of the request
imem_ack  input  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  input  32  instruction word, valid with imem_ack
inst_valid  output  1  FIFO head valid for decode
inst  output  32  FIFO head instruction word
inst_pc  output  ADDR_W  word address of inst
inst_ready  input  1  decode consumes head when inst_valid && inst_ready
redirect  input  1  branch/exception taken; flush and refetch
redirect_addr  input  ADDR_W  new fetch word address
halt_req  input  1  stop issuing new fetches
halted  output  1  fetch stopped: no request in flight, halt_req high
fifo_level  output  $clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Reset values (async on rst high): imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0, fifo_level=0. FSM enters IDLE. Next fetch address is RESET_PC.
- FSM states:
  - IDLE: no request in flight.
  - WAIT: imem_req=1 and awaiting ack.
  - HALTED: stopped.
- IDLE -> WAIT when !halt_req && !redirect && (fifo_level + pending) < DEPTH. This issues next_addr. imem_req rises the cycle after the decision (registered output).
- In WAIT, imem_req and imem_addr are held stable until imem_ack. On ack the word is pushed with its address, next_addr increments by 1 (wraps mod 2^ADDR_W), and the FSM returns to IDLE. A back-to-back request may be issued in the following cycle. Maximum rate is one word per 2 cycles.
- Memory may ack in the same cycle imem_req first appears. Ack is ignored while imem_req=0.
- FIFO: circular buffer, read/write pointers wrap at DEPTH. Push and pop in the same cycle are legal at any level, and the level is unchanged. Issue is gated on the level, so a push never overflows. Pop when empty cannot occur because inst_valid=0.
- inst/inst_pc/inst_valid show the FIFO head combinationally from registered storage. inst holds its last value when empty.
- redirect (highest priority, single-cycle pulse):
  - FIFO cleared next cycle (fifo_level=0, inst_valid=0).
  - next_addr=redirect_addr.
  - A pop that is concurrent with redirect is ignored.
- redirect while in WAIT: the request cannot be aborted. imem_req stays high until ack and the returned word is discarded (stale flag). The first new request is then issued to redirect_addr.
- redirect in the same cycle as imem_ack: the word is discarded.
- halt_req: no new requests are issued. An in-flight request completes and its word is pushed. Then the FSM goes to HALTED and halted=1. The FIFO remains poppable.
- HALTED -> IDLE when halt_req=0 (halted drops the next cycle). A redirect during HALTED updates next_addr and flushes, and the FSM stays HALTED while halt_req is held.
- rst mid-transaction: imem_req drops immediately (async). A late ack after reset is ignored because imem_req=0.

Optional Feature:
ARM_FETCH_STATS_EN:
- When defined, adds outputs stat_fetched[31:0] and stat_discarded[31:0], both reset to 0. stat_fetched increments on every accepted ack. stat_discarded adds one for each stale ack, plus the number of FIFO entries flushed by redirect. Both counters wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=0x100, memory acks every cycle, inst_ready=0 -> requests to 0x100..0x103, then no further req; fifo_level=4, head inst_pc=0x100.
- Continuous inst_ready=1, 0-wait memory -> inst_pc sequence 0x100,0x101,0x102… with no gaps larger than 2 cycles; fifo_level never exceeds DEPTH.
- Memory with 3-cycle ack delay; redirect to 0x2000 one cycle after req at 0x105 -> req/addr held at 0x105 until ack; that word is never valid; the next req is addr 0x2000; the first popped inst_pc is 0x2000.
- FIFO full (4 entries); redirect and inst_ready in the same cycle -> next cycle fifo_level=0, inst_valid=0; no entry is delivered.
- halt_req asserted mid-WAIT -> ack at 0x10A is pushed, halted=1 the next cycle, no further req. Deassert -> halted=0, req issued for 0x10B.
- ARM_FETCH_STATS_EN defined: 6 fetches, one redirect flushing 3 entries plus one stale ack -> stat_fetched=7, stat_discarded=4.

Source files
------------

// File: rtl/arm_fetch_if.sv
// Fetch-unit bundle: instruction-memory req/ack, decode valid/ready, redirect and halt control.
// Counter outputs are present only when ARM_FETCH_STATS_EN is defined.
interface arm_fetch_if #(
  parameter int ADDR_W = 30,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halt_req;
  logic              halted;
  logic [LVL_W-1:0]  fifo_level;

`ifdef ARM_FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_discarded;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, halted, fifo_level,
           stat_fetched, stat_discarded,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_addr, halt_req
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, halted, fifo_level,
           stat_fetched, stat_discarded,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_addr, halt_req
  );
`else
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, halted, fifo_level,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_addr, halt_req
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, halted, fifo_level,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_addr, halt_req
  );
`endif
endinterface

// File: rtl/arm_fetch_unit.sv
// Instruction-fetch front end: req/ack memory port, prefetch FIFO, redirect flush, halt/drain.
// Optional fetch/discard counters are enabled by defining ARM_FETCH_STATS_EN.
module arm_fetch_unit #(
  parameter int                ADDR_W   = 30,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  arm_fetch_if.master bus
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

  typedef struct packed {
    logic [31:0]       word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic              stale;
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  head_ptr;
  logic [LVL_W-1:0]  level;
  logic              ack_fire;
  logic              push;
  logic              pop;
  logic              can_issue;

  // An ack only counts while a request is out; stale or redirect-coincident words are dropped.
  assign ack_fire  = bus.imem_req && bus.imem_ack;
  assign push      = ack_fire && !stale && !bus.redirect;
  assign pop       = bus.inst_valid && bus.inst_ready && !bus.redirect;
  assign can_issue = !bus.halt_req && !bus.redirect && (level < FULL_LVL);

  // NOTE: all state here uses <= so every branch reads the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
      bus.halted    <= 1'b0;
      next_addr     <= RESET_PC;
      stale         <= 1'b0;
    end else begin
      if (bus.redirect)  next_addr <= bus.redirect_addr;
      else if (push)     next_addr <= next_addr + ADDR_W'(1);

      // A request in flight cannot be aborted, so its eventual word is marked for discard.
      if (ack_fire)                          stale <= 1'b0;
      else if (bus.redirect && bus.imem_req) stale <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.halt_req) begin
            state      <= HALTED;
            bus.halted <= 1'b1;
          end else if (can_issue) begin
            state         <= WAIT;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= next_addr;
          end
        end
        WAIT: begin
          if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            if (bus.halt_req) begin
              state      <= HALTED;
              bus.halted <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALTED: begin
          if (!bus.halt_req) begin
            state      <= IDLE;
            bus.halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the small entry array is reset so inst/inst_pc leave reset at zero instead of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry_t'{word: bus.imem_rdata, pc: bus.imem_addr};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  // When empty, show the most recently written slot so inst holds its last value.
  assign head_ptr       = (level != '0) ? rd_ptr : rd_ptr - PTR_W'(1);
  assign bus.inst_valid = (level != '0);
  assign bus.inst       = mem[head_ptr].word;
  assign bus.inst_pc    = mem[head_ptr].pc;
  assign bus.fifo_level = level;

`ifdef ARM_FETCH_STATS_EN
  logic discard_ack;
  assign discard_ack = ack_fire && (stale || bus.redirect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stat_fetched   <= '0;
      bus.stat_discarded <= '0;
    end else begin
      if (ack_fire) bus.stat_fetched <= bus.stat_fetched + 32'd1;
      bus.stat_discarded <= bus.stat_discarded
                          + (bus.redirect ? 32'(level) : 32'd0)
                          + (discard_ack  ? 32'd1      : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_arm_fetch_unit.sv
// Directed bench for arm_fetch_unit: fill/stream table, redirect/halt/reset sequences,
// and the fetch/discard counters when ARM_FETCH_STATS_EN is defined.
module tb_arm_fetch_unit;
  localparam int AW = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int   ack_delay = 0;
  int   wait_cnt  = 0;
  logic force_ack = 1'b0;

  logic [AW-1:0] pop_q [$];
  logic [AW-1:0] req_q [$];
  logic [AW-1:0] held_addr = '0;
  logic          req_prev  = 1'b0;
  logic          gap_chk   = 1'b0;
  int            last_pop  = -1;
  int            cyc       = 0;

  arm_fetch_if #(.ADDR_W(AW), .DEPTH(4)) bus ();

  arm_fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(30'h100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return {2'b10, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks after ack_delay cycles of a held request.
  always @(negedge clk) begin
    if (bus.imem_req && wait_cnt >= ack_delay) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word_of(bus.imem_addr);
      wait_cnt       = 0;
    end else if (bus.imem_req) begin
      bus.imem_ack   = force_ack;
      bus.imem_rdata = 32'hDEAD_BEEF;
      wait_cnt++;
    end else begin
      bus.imem_ack   = force_ack;
      bus.imem_rdata = 32'hDEAD_BEEF;
      wait_cnt       = 0;
    end
  end

  // Monitor: logs issued requests and delivered words, checks hold/data/level/gap rules.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      req_prev = 1'b0;
    end else begin
      if (bus.imem_req && !req_prev) begin
        req_q.push_back(bus.imem_addr);
        held_addr = bus.imem_addr;
      end else if (bus.imem_req) begin
        check("req_addr_held", 32'(bus.imem_addr), 32'(held_addr));
      end
      req_prev = bus.imem_req;
      if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
        pop_q.push_back(bus.inst_pc);
        check("pop_word", bus.inst, word_of(bus.inst_pc));
        if (gap_chk && last_pop >= 0) check("pop_gap_le_2", 32'(cyc - last_pop <= 2), 32'd1);
        last_pop = cyc;
      end
      check("level_le_depth", 32'(bus.fifo_level <= 3'd4), 32'd1);
      cyc++;
    end
  end

  task automatic do_reset();
    bus.inst_ready = 1'b0;
    bus.redirect   = 1'b0;
    bus.halt_req   = 1'b0;
    force_ack      = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    pop_q.delete();
    req_q.delete();
  endtask

  task automatic wait_req(input logic [AW-1:0] a, input int budget, input string nm);
    int n = 0;
    while (!(bus.imem_req && bus.imem_addr == a) && n < budget) begin
      step();
      n++;
    end
    check(nm, 32'(bus.imem_req && bus.imem_addr == a), 32'd1);
  endtask

  task automatic wait_pops(input int cnt, input int budget, input string nm);
    int n = 0;
    while (pop_q.size() < cnt && n < budget) begin
      step();
      n++;
    end
    check(nm, 32'(pop_q.size() >= cnt), 32'd1);
  endtask

  typedef struct {
    logic          ready;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_level;
    logic [AW-1:0] exp_pc;
  } vec_t;

  vec_t vt [14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b1, 30'h100, 3'd0, 30'h000};
    vt[1]  = '{1'b0, 1'b0, 30'h000, 3'd1, 30'h100};
    vt[2]  = '{1'b0, 1'b1, 30'h101, 3'd1, 30'h100};
    vt[3]  = '{1'b0, 1'b0, 30'h000, 3'd2, 30'h100};
    vt[4]  = '{1'b0, 1'b1, 30'h102, 3'd2, 30'h100};
    vt[5]  = '{1'b0, 1'b0, 30'h000, 3'd3, 30'h100};
    vt[6]  = '{1'b0, 1'b1, 30'h103, 3'd3, 30'h100};
    vt[7]  = '{1'b0, 1'b0, 30'h000, 3'd4, 30'h100};
    vt[8]  = '{1'b0, 1'b0, 30'h000, 3'd4, 30'h100};
    vt[9]  = '{1'b1, 1'b0, 30'h000, 3'd4, 30'h100};
    vt[10] = '{1'b1, 1'b0, 30'h000, 3'd3, 30'h101};
    vt[11] = '{1'b1, 1'b1, 30'h104, 3'd2, 30'h102};
    vt[12] = '{1'b1, 1'b0, 30'h000, 3'd2, 30'h103};
    vt[13] = '{1'b1, 1'b1, 30'h105, 3'd1, 30'h104};

    bus.inst_ready    = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.halt_req      = 1'b0;

    // Reset values
    step();
    check("rst_req",    32'(bus.imem_req),   32'd0);
    check("rst_addr",   32'(bus.imem_addr),  32'h100);
    check("rst_valid",  32'(bus.inst_valid), 32'd0);
    check("rst_inst",   bus.inst,            32'd0);
    check("rst_pc",     32'(bus.inst_pc),    32'd0);
    check("rst_halted", 32'(bus.halted),     32'd0);
    check("rst_level",  32'(bus.fifo_level), 32'd0);
    step();
    rst = 1'b0;
    pop_q.delete();

    // Fill with inst_ready low, then start draining
    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("t1_req[%0d]", i), 32'(bus.imem_req), 32'(vt[i].exp_req));
      if (vt[i].exp_req)
        check($sformatf("t1_addr[%0d]", i), 32'(bus.imem_addr), 32'(vt[i].exp_addr));
      check($sformatf("t1_level[%0d]", i), 32'(bus.fifo_level), 32'(vt[i].exp_level));
      check($sformatf("t1_valid[%0d]", i), 32'(bus.inst_valid), 32'(vt[i].exp_level != 3'd0));
      if (vt[i].exp_level != 3'd0)
        check($sformatf("t1_pc[%0d]", i), 32'(bus.inst_pc), 32'(vt[i].exp_pc));
      check($sformatf("t1_halted[%0d]", i), 32'(bus.halted), 32'd0);
      bus.inst_ready = vt[i].ready;
    end

    // Continuous streaming
    last_pop = -1;
    gap_chk  = 1'b1;
    for (int i = 0; i < 40; i++) step();
    gap_chk  = 1'b0;
    bus.inst_ready = 1'b0;
    check("t2_pop_count", 32'(pop_q.size() >= 15), 32'd1);
    for (int i = 0; i < pop_q.size(); i++)
      check($sformatf("t2_pop_pc[%0d]", i), 32'(pop_q[i]), 32'h100 + 32'(i));

    // Redirect while a slow request is in flight
    do_reset();
    ack_delay = 3;
    bus.inst_ready = 1'b1;
    wait_req(30'h105, 60, "t3_req_105_seen");
    step();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 30'h2000;
    pop_q.delete();
    req_q.delete();
    step();
    bus.redirect = 1'b0;
    check("t3_req_held", 32'(bus.imem_req),   32'd1);
    check("t3_addr_held", 32'(bus.imem_addr), 32'h105);
    check("t3_flushed",  32'(bus.fifo_level), 32'd0);
    wait_pops(1, 40, "t3_pop_seen");
    check("t3_first_pop", 32'(pop_q.size() > 0 ? pop_q[0] : 30'h3FFF_FFFF), 32'h2000);
    check("t3_first_req", 32'(req_q.size() > 0 ? req_q[0] : 30'h3FFF_FFFF), 32'h2000);

    // Full FIFO: redirect and inst_ready in the same cycle
    do_reset();
    ack_delay = 0;
    begin
      int n = 0;
      while (bus.fifo_level != 3'd4 && n < 30) begin
        step();
        n++;
      end
    end
    step();
    check("t4_full",     32'(bus.fifo_level), 32'd4);
    check("t4_head_pc",  32'(bus.inst_pc),    32'h100);
    bus.redirect      = 1'b1;
    bus.redirect_addr = 30'h300;
    bus.inst_ready    = 1'b1;
    pop_q.delete();
    step();
    bus.redirect = 1'b0;
    check("t4_level0", 32'(bus.fifo_level), 32'd0);
    check("t4_valid0", 32'(bus.inst_valid), 32'd0);
    wait_pops(1, 20, "t4_pop_seen");
    check("t4_first_pop", 32'(pop_q.size() > 0 ? pop_q[0] : 30'h3FFF_FFFF), 32'h300);

    // Halt asserted mid-WAIT, then release
    do_reset();
    ack_delay = 3;
    bus.inst_ready = 1'b1;
    wait_req(30'h10A, 100, "t5_req_10a_seen");
    bus.halt_req = 1'b1;
    begin
      int n = 0;
      while (bus.imem_req && n < 10) begin
        step();
        n++;
      end
    end
    check("t5_req_done", 32'(bus.imem_req), 32'd0);
    check("t5_halted",   32'(bus.halted),   32'd1);
    req_q.delete();
    for (int i = 0; i < 6; i++) step();
    check("t5_no_req",   32'(req_q.size()), 32'd0);
    check("t5_halted_hold", 32'(bus.halted), 32'd1);
    check("t5_last_pop", 32'(pop_q.size() > 0 ? pop_q[pop_q.size()-1] : 30'h3FFF_FFFF), 32'h10A);
    bus.halt_req = 1'b0;
    step();
    check("t5_unhalted", 32'(bus.halted),   32'd0);
    step();
    check("t5_resume_req",  32'(bus.imem_req),  32'd1);
    check("t5_resume_addr", 32'(bus.imem_addr), 32'h10B);

    // Reset mid-transaction, late ack ignored
    do_reset();
    ack_delay = 3;
    wait_req(30'h100, 10, "t6_req_seen");
    step();
    rst = 1'b1;
    #1;
    check("t6_async_req", 32'(bus.imem_req), 32'd0);
    bus.halt_req = 1'b1;
    step();
    step();
    rst = 1'b0;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) step();
    force_ack = 1'b0;
    check("t6_level",  32'(bus.fifo_level), 32'd0);
    check("t6_valid",  32'(bus.inst_valid), 32'd0);
    check("t6_req",    32'(bus.imem_req),   32'd0);
    check("t6_halted", 32'(bus.halted),     32'd1);
    bus.halt_req = 1'b0;

`ifdef ARM_FETCH_STATS_EN
    // Counters: 6 good fetches, flush of 3 entries plus one stale ack
    do_reset();
    ack_delay = 3;
    bus.inst_ready = 1'b1;
    wait_pops(3, 60, "t7_three_pops");
    bus.inst_ready = 1'b0;
    wait_req(30'h106, 60, "t7_req_106_seen");
    check("t7_level3", 32'(bus.fifo_level), 32'd3);
    bus.redirect      = 1'b1;
    bus.redirect_addr = 30'h400;
    bus.halt_req      = 1'b1;
    step();
    bus.redirect = 1'b0;
    begin
      int n = 0;
      while (!bus.halted && n < 10) begin
        step();
        n++;
      end
    end
    step();
    step();
    check("t7_stat_fetched",   bus.stat_fetched,   32'd7);
    check("t7_stat_discarded", bus.stat_discarded, 32'd4);
    bus.halt_req = 1'b0;
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
